// File: rtl/writeback_regfile.sv
// Writeback result select and 31-entry register file with write-first bypass.
// x0 is hardwired to zero; also exports committed x10 and a retire counter.
module writeback_regfile #(
  parameter int DATA_WIDTH             = 32,
  parameter int REGISTER_ADDRESS_WIDTH = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              RegWriteW,
  input  logic [1:0]                        ResultSrcW,
  input  logic [DATA_WIDTH-1:0]             ALUResultW,
  input  logic [DATA_WIDTH-1:0]             ReadDataW,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW,
  input  logic [DATA_WIDTH-1:0]             PCPlus4W,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] A1,
  input  logic [REGISTER_ADDRESS_WIDTH-1:0] A2,
  output logic [DATA_WIDTH-1:0]             RD1,
  output logic [DATA_WIDTH-1:0]             RD2,
  output logic [DATA_WIDTH-1:0]             ResultW,
  output logic [DATA_WIDTH-1:0]             a0,
  output logic [31:0]                       RetireCount
);

  localparam int NREG = 1 << REGISTER_ADDRESS_WIDTH;
  localparam logic [REGISTER_ADDRESS_WIDTH-1:0] A0_IDX = 10;

  logic [DATA_WIDTH-1:0] regs [1:NREG-1];
  logic [31:0]           retire_count;
  logic                  commit;

  always_comb begin
    ResultW = ALUResultW;
    unique case (ResultSrcW)
      2'b01:   ResultW = ReadDataW;
      2'b10:   ResultW = PCPlus4W;
      default: ResultW = ALUResultW;
    endcase
  end

  assign commit = rst_n & RegWriteW & (RdW != '0);

  always_comb begin
    RD1 = '0;
    if (rst_n && A1 != '0) begin
      if (commit && RdW == A1)
        RD1 = ResultW;
      else
        RD1 = regs[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (rst_n && A2 != '0) begin
      if (commit && RdW == A2)
        RD2 = ResultW;
      else
        RD2 = regs[A2];
    end
  end

  // a0 is the committed value only, never the bypassed one
  assign a0 = rst_n ? regs[A0_IDX] : '0;
  assign RetireCount = retire_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++)
        regs[i] <= '0;
      retire_count <= '0;
    end else if (commit) begin
      regs[RdW]    <= ResultW;
      retire_count <= retire_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed vector table plus
// randomized traffic against an array-based reference model.
module tb_writeback_regfile;

  logic        clk;
  logic        rst_n;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [31:0] ALUResultW;
  logic [31:0] ReadDataW;
  logic [4:0]  RdW;
  logic [31:0] PCPlus4W;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] ResultW;
  logic [31:0] a0;
  logic [31:0] RetireCount;

  int checks = 0;
  int errors = 0;

  writeback_regfile dut (
    .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ALUResultW(ALUResultW),
    .ReadDataW(ReadDataW), .RdW(RdW), .PCPlus4W(PCPlus4W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .ResultW(ResultW), .a0(a0), .RetireCount(RetireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] rdd;
    logic [4:0]  rd;
    logic [31:0] pc4;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_res;
    logic [31:0] e_a0;
    logic        chk_cnt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(
    input logic r, input logic w, input logic [1:0] s,
    input logic [31:0] alu, input logic [31:0] rdd,
    input logic [4:0] rd, input logic [31:0] pc4,
    input logic [4:0] x1, input logic [4:0] x2,
    input logic [31:0] e1, input logic [31:0] e2,
    input logic [31:0] er, input logic [31:0] ea,
    input logic cc, input logic [31:0] ec);
    vec_t v;
    v.rst_n = r; v.we = w; v.src = s; v.alu = alu;
    v.rdd = rdd; v.rd = rd; v.pc4 = pc4; v.a1 = x1; v.a2 = x2;
    v.e_rd1 = e1; v.e_rd2 = e2; v.e_res = er; v.e_a0 = ea;
    v.chk_cnt = cc; v.e_cnt = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [1:0] s, input logic [31:0] alu,
                       input logic [31:0] rdd, input logic [4:0] rd,
                       input logic [31:0] pc4, input logic [4:0] x1,
                       input logic [4:0] x2);
    rst_n = r; RegWriteW = w; ResultSrcW = s; ALUResultW = alu;
    ReadDataW = rdd; RdW = rd; PCPlus4W = pc4; A1 = x1; A2 = x2;
  endtask

  // reference model state
  logic [31:0] mdl [32];
  logic [31:0] mcnt;

  function automatic logic [31:0] m_res(input logic [1:0] s,
    input logic [31:0] alu, input logic [31:0] rdd,
    input logic [31:0] pc4);
    if (s == 2'd1) return rdd;
    if (s == 2'd2) return pc4;
    return alu;
  endfunction

  function automatic logic [31:0] m_read(input logic r, input logic w,
    input logic [4:0] rd, input logic [31:0] res, input logic [4:0] a);
    if (!r || a == 5'd0) return 32'd0;
    if (w && rd == a) return res;
    return mdl[a];
  endfunction

  initial begin
    drive(1'b0, 1'b0, 2'd0, 0, 0, 5'd0, 0, 5'd0, 5'd0);

    tbl[0]  = mk(0,1,0,32'h77,0,5,0,5,5, 0,0,32'h77,0, 0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,5,31, 0,0,0,0, 1,0);
    tbl[2]  = mk(1,0,0,0,0,0,0,5,31, 0,0,0,0, 1,0);
    tbl[3]  = mk(1,1,0,32'h1234,0,10,0,10,0,
                 32'h1234,0,32'h1234,0, 1,0);
    tbl[4]  = mk(1,0,0,0,0,0,0,10,10,
                 32'h1234,32'h1234,0,32'h1234, 1,1);
    tbl[5]  = mk(1,1,1,32'h11,32'hDEADBEEF,3,0,3,3,
                 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,32'h1234, 1,1);
    tbl[6]  = mk(1,1,2,32'h11,0,3,32'h104,3,3,
                 32'h104,32'h104,32'h104,32'h1234, 1,2);
    tbl[7]  = mk(1,0,3,32'h99,0,0,0,3,10,
                 32'h104,32'h1234,32'h99,32'h1234, 1,3);
    tbl[8]  = mk(1,1,0,32'hFFFFFFFF,0,0,0,0,3,
                 0,32'h104,32'hFFFFFFFF,32'h1234, 1,3);
    tbl[9]  = mk(1,0,0,0,0,0,0,0,0, 0,0,0,32'h1234, 1,3);
    tbl[10] = mk(0,1,0,32'h55,0,7,0,7,10, 0,0,32'h55,0, 1,3);
    tbl[11] = mk(1,1,0,32'h55,0,7,0,7,10, 32'h55,0,32'h55,0, 1,0);
    tbl[12] = mk(1,0,0,0,0,0,0,7,7, 32'h55,32'h55,0,0, 1,1);

    @(posedge clk); #1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].we, tbl[i].src, tbl[i].alu,
            tbl[i].rdd, tbl[i].rd, tbl[i].pc4, tbl[i].a1, tbl[i].a2);
      @(negedge clk);
      check($sformatf("v%0d.RD1", i), RD1, tbl[i].e_rd1);
      check($sformatf("v%0d.RD2", i), RD2, tbl[i].e_rd2);
      check($sformatf("v%0d.ResultW", i), ResultW, tbl[i].e_res);
      check($sformatf("v%0d.a0", i), a0, tbl[i].e_a0);
      if (tbl[i].chk_cnt)
        check($sformatf("v%0d.RetireCount", i), RetireCount,
              tbl[i].e_cnt);
      @(posedge clk); #1;
    end

    // random phase starts from a clean reset
    drive(1'b0, 1'b0, 2'd0, 0, 0, 5'd0, 0, 5'd0, 5'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
    mcnt = 32'd0;

    for (int n = 0; n < 1500; n++) begin
      logic        r, w;
      logic [1:0]  s;
      logic [4:0]  rd, x1, x2;
      logic [31:0] alu, rdd, pc4, res;
      r   = ($urandom_range(0, 39) != 0);
      w   = ($urandom_range(0, 3) != 0);
      s   = 2'($urandom_range(0, 3));
      rd  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      if ($urandom_range(0, 5) == 0) rd = 5'd10;
      alu = $urandom; rdd = $urandom; pc4 = $urandom;
      x1  = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      x2  = ($urandom_range(0, 2) == 0) ? x1 : 5'($urandom);
      if ($urandom_range(0, 3) == 0) x2 = rd;
      drive(r, w, s, alu, rdd, rd, pc4, x1, x2);
      res = m_res(s, alu, rdd, pc4);
      @(negedge clk);
      check("rnd.ResultW", ResultW, res);
      check("rnd.RD1", RD1, m_read(r, w, rd, res, x1));
      check("rnd.RD2", RD2, m_read(r, w, rd, res, x2));
      check("rnd.a0", a0, r ? mdl[10] : 32'd0);
      check("rnd.RetireCount", RetireCount, mcnt);
      @(posedge clk); #1;
      if (!r) begin
        for (int k = 0; k < 32; k++) mdl[k] = 32'd0;
        mcnt = 32'd0;
      end else if (w && rd != 5'd0) begin
        mdl[rd] = res;
        mcnt = mcnt + 32'd1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of every data word and register.
REQ-002 Parameter REGISTER_ADDRESS_WIDTH, default 5, register index width (2^5 = 32 architectural registers).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 RegWriteW  input  1  write-back enable from the writeback pipeline register.
REQ-006 ResultSrcW  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 reserved.
REQ-007 ALUResultW  input  DATA_WIDTH  ALU result.
REQ-008 ReadDataW  input  DATA_WIDTH  load data.
REQ-009 RdW  input  REGISTER_ADDRESS_WIDTH  destination register index.
REQ-010 PCPlus4W  input  DATA_WIDTH  link address for JAL/JALR.
REQ-011 A1, A2  input  REGISTER_ADDRESS_WIDTH each  decode-stage source register indices.
REQ-012 RD1, RD2  output  DATA_WIDTH each  source operand values for A1, A2.
REQ-013 ResultW  output  DATA_WIDTH  selected write-back value, exported for the execute-stage forwarding mux.
REQ-014 a0  output  DATA_WIDTH  current committed contents of x10, for debug/testbench.
REQ-015 RetireCount  output  32  count of committed register writes.

Function
REQ-016 ResultW SHALL be combinational: 00 -> ALUResultW, 01 -> ReadDataW, 10 -> PCPlus4W, 11 -> ALUResultW.
REQ-017 Register file SHALL hold 31 writable registers x1..x31; x0 SHALL read 0 always and never be stored.
REQ-018 Commit SHALL occur on posedge clk when rst_n=1, RegWriteW=1 and RdW!=0: reg[RdW] <= ResultW.
REQ-019 RegWriteW=1 with RdW=0 SHALL change no state and SHALL NOT increment RetireCount.
REQ-020 Reads SHALL be combinational, zero latency.
REQ-021 Read bypass (write-first): if RegWriteW=1, RdW!=0, RdW==A1, then RD1=ResultW in the same cycle; same rule for A2/RD2, independently.
REQ-022 A1==A2 SHALL return identical values on RD1 and RD2, bypass included.
REQ-023 A1=0 or A2=0 SHALL return 0 regardless of any pending write to RdW=0.
REQ-024 a0 SHALL show committed x10 state only (no bypass); updates the cycle after commit.
REQ-025 RetireCount SHALL increment by 1 on each commit per REQ-018; wraps 0xFFFFFFFF -> 0 with no flag.
REQ-026 At most one write per cycle; a new write to the same RdW in the next cycle SHALL overwrite (last write wins).

Reset
REQ-027 On posedge clk with rst_n=0: x1..x31 <= 0, RetireCount <= 0.
REQ-028 While rst_n=0: writes suppressed, bypass disabled, RD1=RD2=a0=0 irrespective of inputs; ResultW remains the combinational mux.
REQ-029 Reset asserted in a cycle with RegWriteW=1 SHALL discard that write; the first commit after release SHALL be in the first cycle with rst_n=1.

Verification
REQ-030 Reset 2 cycles, release; A1=5, A2=31 -> RD1=0, RD2=0, RetireCount=0, a0=0.
REQ-031 RegWriteW=1, RdW=10, ResultSrcW=00, ALUResultW=0x0000_1234, A1=10 -> RD1=0x1234 same cycle (bypass); next cycle with RegWriteW=0 -> RD1=0x1234, a0=0x1234, RetireCount=1.
REQ-032 RdW=3, ResultSrcW=01, ReadDataW=0xDEAD_BEEF, then RdW=3, ResultSrcW=10, PCPlus4W=0x0000_0104 on consecutive cycles; A1=A2=3 -> 0xDEADBEEF then 0x104 via bypass, final committed 0x104, RetireCount=2.
REQ-033 RegWriteW=1, RdW=0, ALUResultW=0xFFFF_FFFF, A1=0 -> RD1=0, ResultW=0xFFFFFFFF, RetireCount unchanged.
REQ-034 rst_n=0 coincident with RegWriteW=1, RdW=7, value 0x55 -> after edge x7=0, RetireCount=0; write repeated with rst_n=1 -> x7=0x55.
REQ-035 Force RetireCount to 0xFFFF_FFFF via 2^32-1 commits (or a test backdoor), then one more commit -> RetireCount=0.
